// File: rtl/mult_rr_arbiter.sv
// ---------------------------------------------------------------------------
// mult_rr_arbiter
//
// Round-robin front end that lets NUM_REQ FDCT stage engines share one
// combinational multiplier (param_mult, instantiated outside this block).
// Each cycle at most one requester is granted. Its operands are steered to the
// multiplier, and the product is captured into a single registered response
// slot tagged with the requester index. A fresh product can replace the slot in
// the same cycle the consumer drains it, so throughput is one multiply per
// cycle while the consumer keeps resp_ready high.
//
// Ports
//   clk         clock, all state on posedge
//   reset       synchronous, active-high; clears slot and priority pointer
//   req_valid   [NUM_REQ]           requester i has an operand pair
//   req_ready   [NUM_REQ]           one-hot grant (or 0), combinational
//   req_a/req_b [NUM_REQ*WIDTH_IN]  operands, requester i at [i*WIDTH_IN +: WIDTH_IN]
//   mult_a/b    [WIDTH_IN]          operands to the shared multiplier (0 when idle)
//   mult_y      [WIDTH_OUT]         product from the shared multiplier
//   resp_valid  response slot holds a product
//   resp_ready  consumer takes the response this cycle
//   resp_y      [WIDTH_OUT]         registered product
//   resp_id     [ID_W]              requester that produced resp_y
// ---------------------------------------------------------------------------
module mult_rr_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 16,
  localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  output logic [NUM_REQ-1:0]           req_ready,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_a,
  input  logic [NUM_REQ*WIDTH_IN-1:0]  req_b,
  output logic [WIDTH_IN-1:0]          mult_a,
  output logic [WIDTH_IN-1:0]          mult_b,
  input  logic [WIDTH_OUT-1:0]         mult_y,
  output logic                         resp_valid,
  input  logic                         resp_ready,
  output logic [WIDTH_OUT-1:0]         resp_y,
  output logic [ID_W-1:0]              resp_id
);

  logic [ID_W-1:0]      ptr_r;
  logic                 resp_valid_r;
  logic [WIDTH_OUT-1:0] resp_y_r;
  logic [ID_W-1:0]      resp_id_r;

  logic                 can_acc_s;
  logic                 found_s;
  logic                 grant_s;
  logic [ID_W-1:0]      gnt_id_s;
  logic [ID_W:0]        sum_s;
  logic [ID_W-1:0]      idx_s;

  // The slot can take a new product when empty or being drained; never during reset.
  assign can_acc_s = ~reset & (~resp_valid_r | resp_ready);
  assign grant_s   = can_acc_s & found_s;

  // Round-robin search starting at ptr_r, wrapping modulo NUM_REQ.
  always_comb begin
    found_s  = 1'b0;
    gnt_id_s = '0;
    sum_s    = '0;
    idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum_s = {1'b0, ptr_r} + (ID_W+1)'(k);
      if (sum_s >= (ID_W+1)'(NUM_REQ)) begin
        sum_s = sum_s - (ID_W+1)'(NUM_REQ);
      end else begin
        sum_s = sum_s;
      end
      idx_s = sum_s[ID_W-1:0];
      if (!found_s && req_valid[idx_s]) begin
        found_s  = 1'b1;
        gnt_id_s = idx_s;
      end else begin
        found_s  = found_s;
      end
    end
  end

  // One-hot ready and operand mux; operands are forced to zero when nothing is granted.
  always_comb begin
    req_ready = '0;
    mult_a    = '0;
    mult_b    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_s && (gnt_id_s == ID_W'(i))) begin
        req_ready[i] = 1'b1;
        mult_a       = req_a[i*WIDTH_IN +: WIDTH_IN];
        mult_b       = req_b[i*WIDTH_IN +: WIDTH_IN];
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Response slot and priority pointer; an accept wins over a plain drain so the slot never bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      resp_valid_r <= 1'b0;
      resp_y_r     <= '0;
      resp_id_r    <= '0;
      ptr_r        <= '0;
    end else if (grant_s) begin
      resp_valid_r <= 1'b1;
      resp_y_r     <= mult_y;
      resp_id_r    <= gnt_id_s;
      if (gnt_id_s == ID_W'(NUM_REQ-1)) begin
        ptr_r <= '0;
      end else begin
        ptr_r <= gnt_id_s + ID_W'(1);
      end
    end else if (resp_valid_r && resp_ready) begin
      resp_valid_r <= 1'b0;
    end else begin
      resp_valid_r <= resp_valid_r;
    end
  end

  assign resp_valid = resp_valid_r;
  assign resp_y     = resp_y_r;
  assign resp_id    = resp_id_r;

endmodule
